task_2_seq_ctrl: RTL and testbench
==================================

Name: task_2_seq_ctrl

Overview:
Packet sequencer for the task_2 datapath (input byte buffer -> digital_circuit -> output buffer -> 32-bit answer stream). It sequences one packet at a time through four phases:
- Load input bytes.
- Feed them to the circuit.
- Collect the 16-bit results.
- Stream the answer to the task manager.

It owns all buffer addresses, write enables and handshakes, so both buffers reduce to plain RAMs.

Parameters:
NUM_WORDS_IN, 256, input buffer depth in bytes (max packet length); AW = clog2(NUM_WORDS_IN)
DATA_WIDTH_OUT, 16, circuit result width; fixed at 16, so two results per 32-bit answer word
DRAIN_TIMEOUT, 64, max idle cycles waiting for i_dc_valid in DRAIN before forcing SEND

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_tdata_valid  in  1  input byte valid
i_tdata_last  in  1  last byte of packet
o_tready  out  1  task_data_request; high only in LOAD
o_in_wr_en  out  1  input buffer write strobe (= i_tdata_valid & o_tready)
o_in_wr_addr  out  AW  input buffer write address
o_in_rd_addr  out  AW  input buffer read address (sync RAM, 1-cycle read latency)
o_dc_valid  out  1  i_valid to digital_circuit
i_dc_valid  in  1  o_valid from digital_circuit
o_out_wr_en  out  1  output buffer write strobe
o_out_wr_addr  out  AW  output buffer 16-bit write address
i_tmanager_ready  in  1  task manager accepts answer word
o_tanswer_ready  out  1  answer word valid (SEND only)
o_out_rd_addr  out  AW-1  32-bit answer word index (combinational buffer read)
o_tanswer_data_last  out  1  last answer word
o_packet_size_in_bytes  out  12  answer size in bytes
o_busy  out  1  state != IDLE
o_err  out  1  sticky: overflow or drain timeout; cleared on entering LOAD

Behaviour:
- Reset (synchronous, any state, including mid-packet):
  - state=IDLE; all counters 0; every output 0.
  - Any in-flight packet is abandoned.
- States IDLE -> LOAD -> FEED -> DRAIN -> SEND -> IDLE.
- IDLE:
  - Lasts exactly one cycle, then LOAD.
  - o_tready=0.
- LOAD:
  - o_tready=1.
  - Each cycle with i_tdata_valid: write at in_cnt, then in_cnt++.
  - Byte accepted with i_tdata_last: latch N=in_cnt+1, go to FEED.
  - Byte accepted at in_cnt==NUM_WORDS_IN-1 without last: treat it as last, N=NUM_WORDS_IN, set o_err.
  - Valid is never dropped while tready=1.
  - i_tdata_last without valid is ignored.
- FEED:
  - o_in_rd_addr steps 0..N-1, one per cycle.
  - o_dc_valid is the read-issue strobe delayed 1 cycle, so it is aligned with RAM data and asserts exactly N cycles.
  - After issuing address N-1, go to DRAIN. The final o_dc_valid fires in the first DRAIN cycle.
- Result capture (FEED and DRAIN):
  - Each i_dc_valid: o_out_wr_en=1 at out_cnt, then out_cnt++.
  - i_dc_valid in any other state is ignored (no write, no count).
- DRAIN:
  - Go to SEND when out_cnt==N.
  - Idle counter: resets on each i_dc_valid. When it reaches DRAIN_TIMEOUT, go to SEND with the current out_cnt and set o_err.
  - If out_cnt==0 at timeout, skip SEND and go to IDLE.
- SEND:
  - M = ceil(out_cnt/2) answer words.
  - o_packet_size_in_bytes = 2*out_cnt, registered on SEND entry and held through SEND. 512 fits in 12 bits.
  - o_tanswer_ready=1; o_out_rd_addr=k.
  - Transfer when o_tanswer_ready & i_tmanager_ready, then k++.
  - o_tanswer_data_last = (k==M-1) & o_tanswer_ready.
  - After the last transfer, go to IDLE.
  - Stalls of any length hold k and last stable.
  - Odd out_cnt: the upper half of the last word is don't-care, but the size field reports the exact byte count.
- Latency:
  - First o_dc_valid 2 cycles after the last input byte is accepted.
  - SEND entry 1 cycle after the N-th result write.
- Counters are AW+1 bits wide, so N=NUM_WORDS_IN is representable without wrap.

Test Plan:
- Reset, then N=4 bytes with last on the 4th; circuit model latency 3 -> o_dc_valid 4 cycles; 4 out writes at addr 0..3; SEND with size=8, 2 words; last on k=1; back to IDLE; o_err=0.
- N=3, i_tmanager_ready toggled 1,0,0,1 -> size=6, M=2; k holds during stall; o_tanswer_data_last asserted only on the 2nd word.
- 256 bytes with no last -> forced last at byte 256; N=256; o_err=1; size=512; 128 answer words; o_err clears on the next LOAD.
- Circuit model drops the final result -> DRAIN times out after 64 cycles; SEND with size=2*(N-1); o_err=1.
- Assert i_rst mid-FEED with N=10 -> next cycle IDLE, all outputs 0; the next packet (N=1) completes with size=2, single word carrying last.
- Gapped i_tdata_valid (1,0,1,1) and spurious i_dc_valid in LOAD -> addresses contiguous 0..2; no out writes before FEED.

Source files
------------

// File: rtl/task_2_seq_ctrl.sv
// task_2_seq_ctrl: per-packet sequencer LOAD -> FEED -> DRAIN -> SEND owning all buffer addresses and handshakes
module task_2_seq_ctrl #(
  parameter int NUM_WORDS_IN = 256,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int DRAIN_TIMEOUT = 64,
  localparam int AW = $clog2(NUM_WORDS_IN)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tdata_valid,
  input  logic          i_tdata_last,
  output logic          o_tready,
  output logic          o_in_wr_en,
  output logic [AW-1:0] o_in_wr_addr,
  output logic [AW-1:0] o_in_rd_addr,
  output logic          o_dc_valid,
  input  logic          i_dc_valid,
  output logic          o_out_wr_en,
  output logic [AW-1:0] o_out_wr_addr,
  input  logic          i_tmanager_ready,
  output logic          o_tanswer_ready,
  output logic [AW-2:0] o_out_rd_addr,
  output logic          o_tanswer_data_last,
  output logic [11:0]   o_packet_size_in_bytes,
  output logic          o_busy,
  output logic          o_err
);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [AW:0] C1 = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(NUM_WORDS_IN - 1);
  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, SEND} state_t;
  state_t state, state_nx;
  logic [AW:0] in_cnt, n, rd_cnt, out_cnt, out_nx, m;
  logic [AW-1:0] k;
  logic [TW-1:0] idle_cnt;
  logic [11:0] size;
  logic dv, err, accept, done, tmo, xfer;
  assign o_tready = state == LOAD;
  assign accept = i_tdata_valid & o_tready;
  assign o_in_wr_en = accept;
  assign o_in_wr_addr = in_cnt[AW-1:0];
  assign o_in_rd_addr = rd_cnt[AW-1:0];
  assign o_dc_valid = dv;
  assign o_out_wr_en = i_dc_valid & (state == FEED | state == DRAIN);
  assign o_out_wr_addr = out_cnt[AW-1:0];
  // out_nx includes this cycle's write so SEND follows the final write by one cycle
  assign out_nx = out_cnt + {{AW{1'b0}}, o_out_wr_en};
  assign done = state == DRAIN & out_nx == n;
  assign tmo = state == DRAIN & !i_dc_valid & idle_cnt == TW'(DRAIN_TIMEOUT - 1);
  assign m = (out_cnt + C1) >> 1;
  assign o_tanswer_ready = state == SEND;
  assign o_tanswer_data_last = o_tanswer_ready & ({1'b0, k} == m - C1);
  assign xfer = o_tanswer_ready & i_tmanager_ready;
  assign o_out_rd_addr = k[AW-2:0];
  assign o_packet_size_in_bytes = size;
  assign o_busy = state != IDLE;
  assign o_err = err;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = LOAD;
      LOAD: state_nx = accept & (i_tdata_last | in_cnt == FULL) ? FEED : LOAD;
      FEED: state_nx = rd_cnt == n - C1 ? DRAIN : FEED;
      DRAIN: state_nx = done ? SEND : tmo ? (out_cnt == '0 ? IDLE : SEND) : DRAIN;
      SEND: state_nx = xfer & o_tanswer_data_last ? IDLE : SEND;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      in_cnt <= '0;
      n <= '0;
      rd_cnt <= '0;
      out_cnt <= '0;
      k <= '0;
      idle_cnt <= '0;
      size <= '0;
      dv <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      dv <= state == FEED;
      idle_cnt <= state == DRAIN & !i_dc_valid ? idle_cnt + TW'(1) : '0;
      out_cnt <= state == IDLE ? '0 : out_nx;
      rd_cnt <= state == FEED ? rd_cnt + C1 : '0;
      k <= state == SEND ? k + AW'(xfer) : '0;
      if (state == IDLE) begin
        in_cnt <= '0;
        err <= 1'b0;
      end
      if (accept) begin
        in_cnt <= in_cnt + C1;
        if (i_tdata_last | in_cnt == FULL) n <= in_cnt + C1;
        if (!i_tdata_last & in_cnt == FULL) err <= 1'b1;
      end
      if (done | tmo) size <= 12'(out_nx) * 12'(DATA_WIDTH_OUT / 8);
      if (tmo & !done) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_task_2_seq_ctrl.sv
// tb_task_2_seq_ctrl: directed packets with a latency-3 circuit model and scoreboard queues for writes and answers
module tb_task_2_seq_ctrl;
  localparam int AW = 8;
  logic i_clk = 1'b0, i_rst, i_tdata_valid, i_tdata_last, i_tmanager_ready, i_dc_valid;
  logic o_tready, o_in_wr_en, o_dc_valid, o_out_wr_en, o_tanswer_ready, o_tanswer_data_last, o_busy, o_err;
  logic [AW-1:0] o_in_wr_addr, o_in_rd_addr, o_out_wr_addr;
  logic [AW-2:0] o_out_rd_addr;
  logic [11:0] o_packet_size_in_bytes;
  logic [50:0] outs;
  typedef struct {int k; bit last; int size;} ans_t;
  int iq[$], wq[$];
  ans_t aq[$];
  int total = 0, bad = 0, cyc = 0, dcn_seen = 0, last_wr = 0, send_start = 0, cur_n = 1, dcn = 0;
  bit in_send = 0, drop = 0, spur = 0;
  logic [2:0] pv, pl;

  task_2_seq_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tdata_valid(i_tdata_valid), .i_tdata_last(i_tdata_last),
    .o_tready(o_tready), .o_in_wr_en(o_in_wr_en), .o_in_wr_addr(o_in_wr_addr), .o_in_rd_addr(o_in_rd_addr),
    .o_dc_valid(o_dc_valid), .i_dc_valid(i_dc_valid), .o_out_wr_en(o_out_wr_en), .o_out_wr_addr(o_out_wr_addr),
    .i_tmanager_ready(i_tmanager_ready), .o_tanswer_ready(o_tanswer_ready), .o_out_rd_addr(o_out_rd_addr),
    .o_tanswer_data_last(o_tanswer_data_last), .o_packet_size_in_bytes(o_packet_size_in_bytes),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;
  assign outs = {o_tready, o_in_wr_en, o_in_wr_addr, o_in_rd_addr, o_dc_valid, o_out_wr_en, o_out_wr_addr,
                 o_tanswer_ready, o_out_rd_addr, o_tanswer_data_last, o_packet_size_in_bytes, o_busy, o_err};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // circuit model: 3-cycle latency, optionally losing the packet's final result
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (i_rst) begin
      pv <= '0;
      pl <= '0;
      dcn <= 0;
    end else begin
      pv <= {pv[1:0], o_dc_valid};
      pl <= {pl[1:0], o_dc_valid && dcn == cur_n - 1};
      dcn <= !o_busy ? 0 : dcn + (o_dc_valid ? 1 : 0);
    end
  end
  assign i_dc_valid = (pv[2] & !(drop & pl[2])) | spur;

  always @(negedge i_clk) begin
    if (o_in_wr_en) begin
      if (iq.size() == 0) chk("in_spurious", 1, 0);
      else chk("in_addr", o_in_wr_addr, iq.pop_front());
    end
    if (o_out_wr_en) begin
      last_wr = cyc;
      if (wq.size() == 0) chk("out_spurious", 1, 0);
      else chk("out_addr", o_out_wr_addr, wq.pop_front());
    end
    if (o_dc_valid) dcn_seen++;
    if (o_tanswer_ready) begin
      if (!in_send) send_start = cyc;
      if (aq.size() == 0) chk("ans_spurious", 1, 0);
      else begin
        chk("ans_k", o_out_rd_addr, aq[0].k);
        chk("ans_last", o_tanswer_data_last, aq[0].last);
        chk("ans_size", o_packet_size_in_bytes, aq[0].size);
        if (i_tmanager_ready) void'(aq.pop_front());
      end
    end
    in_send = o_tanswer_ready;
  end

  task automatic wait_tready();
    int t = 0;
    while (!o_tready && t < 20) begin
      @(posedge i_clk); #1;
      t++;
    end
    chk("tready_wait", o_tready, 1);
    chk("err_clear_on_load", o_err, 0);
  endtask

  task automatic run_pkt(input int n, input bit nolast, input bit gap, input bit stall, input bit dr, input bit exp_err);
    int r = dr ? n - 1 : n;
    int m = (r + 1) / 2;
    int idx = 0;
    bit seen_idle = 0;
    cur_n = n;
    drop = dr;
    dcn_seen = 0;
    for (int i = 0; i < n; i++) iq.push_back(i);
    for (int i = 0; i < r; i++) wq.push_back(i);
    for (int i = 0; i < m; i++) aq.push_back('{i, i == m - 1, 2 * r});
    wait_tready();
    for (int i = 0; i < n; i++) begin
      if (gap && i == 1) begin
        i_tdata_valid = 0;
        i_tdata_last = 1;
        @(posedge i_clk); #1;
      end
      i_tdata_valid = 1;
      i_tdata_last = (i == n - 1) && !nolast;
      spur = gap;
      #1 if (gap) chk("no_out_wr_in_load", o_out_wr_en, 0);
      @(posedge i_clk); #1;
    end
    i_tdata_valid = 0;
    i_tdata_last = 0;
    spur = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clk); #1;
      if (!o_busy) begin
        seen_idle = 1;
        break;
      end
      if (o_tanswer_ready) begin
        i_tmanager_ready = stall ? (idx % 4 == 0 || idx % 4 == 3) : 1'b1;
        idx++;
      end else i_tmanager_ready = 0;
    end
    i_tmanager_ready = 0;
    chk("reached_idle", seen_idle, 1);
    chk("err", o_err, exp_err);
    chk("dc_valid_count", dcn_seen, n);
    chk("in_queue_empty", iq.size(), 0);
    chk("out_queue_empty", wq.size(), 0);
    chk("ans_queue_empty", aq.size(), 0);
    chk("send_entry_gap", send_start - last_wr, dr ? 65 : 1);
  endtask

  initial begin
    int t;
    i_rst = 1;
    i_tdata_valid = 0;
    i_tdata_last = 0;
    i_tmanager_ready = 0;
    repeat (2) @(posedge i_clk);
    #1 chk("reset_outputs", outs, 0);
    i_rst = 0;
    run_pkt(4, 0, 0, 0, 0, 0);
    run_pkt(3, 0, 0, 1, 0, 0);
    run_pkt(256, 1, 0, 0, 0, 1);
    run_pkt(5, 0, 0, 0, 1, 1);
    cur_n = 10;
    drop = 0;
    for (int i = 0; i < 10; i++) iq.push_back(i);
    wait_tready();
    for (int i = 0; i < 10; i++) begin
      i_tdata_valid = 1;
      i_tdata_last = i == 9;
      @(posedge i_clk); #1;
    end
    i_tdata_valid = 0;
    i_tdata_last = 0;
    t = 0;
    while (!o_dc_valid && t < 20) begin
      @(posedge i_clk); #1;
      t++;
    end
    chk("feed_started", o_dc_valid, 1);
    i_rst = 1;
    @(posedge i_clk); #1;
    i_rst = 0;
    chk("midfeed_reset_outputs", outs, 0);
    chk("midfeed_in_queue", iq.size(), 0);
    run_pkt(1, 0, 0, 0, 0, 0);
    run_pkt(3, 0, 1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
